// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Owns the single-port 2**AW x DW data memory and shares it between the CPU
// data port and the SPI host port. The CPU always gets zero-wait access. Host
// requests are latched one at a time and executed in a CPU-idle cycle. Each
// request is acknowledged with a one-cycle host_ack.
//
// Optional feature: define MEM_ARB_STARVE_EN to enable starvation protection.
// With it, a host request that has waited STARVE_LIMIT cycles in PEND gets a
// forced slot (cpu_hold). Without it, cpu_hold and cpu_conflict are tied low.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   cpu_read/write    CPU strobes, cpu_address / cpu_D request inputs
//   cpu_Q             registered CPU read data (0 when not reading)
//   host_req          single-cycle host request, with host_we/addr/wdata
//   host_busy         a host request is latched and not yet acknowledged
//   host_ack          one-cycle completion pulse
//   host_rdata        host read data, held until the next ack
//   host_overrun      sticky: host_req arrived while busy
//   cpu_hold          forced host slot; CPU must not access memory this cycle
//   cpu_conflict      sticky: CPU accessed memory while cpu_hold was high
module mem_port_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 16,
  parameter int CW           = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [AW-1:0] cpu_address,
  input  logic [DW-1:0] cpu_D,
  output logic [DW-1:0] cpu_Q,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_busy,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          host_overrun,
  output logic          cpu_hold,
  output logic          cpu_conflict
);

  if (2**CW <= STARVE_LIMIT) begin : g_cfg_check
    $error("mem_port_arbiter: CW too narrow for STARVE_LIMIT");
  end

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    DONE
  } state_t;

  state_t state, state_next;

  logic [DW-1:0] mem [0:2**AW-1];

  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  logic cpu_idle;
  logic accept;
  logic host_access;
  logic hold_q;
  logic cpu_wr_en;
  logic cpu_rd_en;
  logic host_wr_en;

  assign cpu_idle = !cpu_read && !cpu_write;

  // In a forced slot the CPU strobes are ignored entirely.
  assign cpu_wr_en = cpu_write && !hold_q;
  assign cpu_rd_en = cpu_read && !hold_q;

  // A host write pending when reset arrives must not reach memory.
  assign host_wr_en = host_access && lat_we && !reset;

  assign host_ack = (state == DONE);

  // ---------------------------------------------------------------------------
  // Host request state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    host_access = 1'b0;
    case (state)
      IDLE: begin
        if (host_req) begin
          accept     = 1'b1;
          state_next = PEND;
        end
      end
      PEND: begin
        if (cpu_idle || hold_q) begin
          host_access = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory array (not reset). CPU and host writes are mutually exclusive by
  // construction: a host access only occurs in a CPU-idle or forced slot.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (cpu_wr_en) begin
      mem[cpu_address] <= cpu_D;
    end else if (host_wr_en) begin
      mem[lat_addr] <= lat_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered datapath and status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_Q        <= '0;
      host_busy    <= 1'b0;
      host_rdata   <= '0;
      host_overrun <= 1'b0;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else begin
      // Read-before-write: the array update above lands after this sample.
      cpu_Q <= cpu_rd_en ? mem[cpu_address] : '0;

      if (accept) begin
        lat_we    <= host_we;
        lat_addr  <= host_addr;
        lat_wdata <= host_wdata;
        host_busy <= 1'b1;
      end else if (state == DONE) begin
        host_busy <= 1'b0;
      end

      // busy stays high through DONE, so a request there is also an overrun.
      if (host_req && host_busy) begin
        host_overrun <= 1'b1;
      end

      if (host_access && !lat_we) begin
        host_rdata <= mem[lat_addr];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation protection
  // ---------------------------------------------------------------------------
`ifdef MEM_ARB_STARVE_EN
  logic [CW-1:0] wait_cnt;
  logic          hold_set;
  logic          conflict_q;

  // The counter reaching the limit schedules exactly one forced slot for the
  // following cycle, in which the access is guaranteed and PEND is left.
  assign hold_set = (state == PEND) && !host_access &&
                    (wait_cnt == CW'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt   <= '0;
      hold_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      if ((state == PEND) && !host_access) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      hold_q <= hold_set;
      if (hold_q && (cpu_read || cpu_write)) begin
        conflict_q <= 1'b1;
      end
    end
  end

  assign cpu_hold     = hold_q;
  assign cpu_conflict = conflict_q;
`else
  assign hold_q       = 1'b0;
  assign cpu_hold     = 1'b0;
  assign cpu_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle-by-cycle vector table covering
// host write/read, CPU-busy deferral, overrun and address boundaries, followed
// by hand-written sequences for reset-mid-operation and forced slots.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_read, cpu_write;
  logic [7:0] cpu_address, cpu_D;
  logic [7:0] cpu_Q;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdata;
  logic       host_busy, host_ack;
  logic [7:0] host_rdata;
  logic       host_overrun, cpu_hold, cpu_conflict;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(8),
    .DW(8),
    .STARVE_LIMIT(16),
    .CW(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cpu_read(cpu_read),
    .cpu_write(cpu_write),
    .cpu_address(cpu_address),
    .cpu_D(cpu_D),
    .cpu_Q(cpu_Q),
    .host_req(host_req),
    .host_we(host_we),
    .host_addr(host_addr),
    .host_wdata(host_wdata),
    .host_busy(host_busy),
    .host_ack(host_ack),
    .host_rdata(host_rdata),
    .host_overrun(host_overrun),
    .cpu_hold(cpu_hold),
    .cpu_conflict(cpu_conflict)
  );

  typedef struct {
    logic       rd, wr;
    logic [7:0] ca, cd;
    logic       hreq, hwe;
    logic [7:0] ha, hwd;
    logic [7:0] eq;
    logic       ebusy, eack;
    logic [7:0] erd;
    logic       eovr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rd, input logic wr, input logic [7:0] ca,
                     input logic [7:0] cd, input logic hreq, input logic hwe,
                     input logic [7:0] ha, input logic [7:0] hwd,
                     input logic [7:0] eq, input logic ebusy, input logic eack,
                     input logic [7:0] erd, input logic eovr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.ca = ca; v.cd = cd;
    v.hreq = hreq; v.hwe = hwe; v.ha = ha; v.hwd = hwd;
    v.eq = eq; v.ebusy = ebusy; v.eack = eack; v.erd = erd; v.eovr = eovr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_D = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
  endtask

  task automatic cpu_rd(input logic [7:0] a);
    idle_inputs();
    cpu_read = 1'b1; cpu_address = a;
    step();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    chk("rst cpu_Q", cpu_Q, 0);
    chk("rst busy", host_busy, 0);
    chk("rst ack", host_ack, 0);
    chk("rst rdata", host_rdata, 0);
    chk("rst overrun", host_overrun, 0);
    chk("rst hold", cpu_hold, 0);
    chk("rst conflict", cpu_conflict, 0);
    reset = 1'b0;

    //   rd wr ca     cd     req we ha     hwd    | eq     bsy ack rdata  ovr
    // host write 0x10=A5, then CPU read-back
    add(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'hA5, 8'h00, 1, 0, 8'h00, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h00, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    add(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 8'hA5, 0, 0, 8'h00, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    // CPU write 0x20=3C, host read 0x20
    add(0, 1, 8'h20, 8'h3C, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    add(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 8'h00, 1, 0, 8'h00, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h3C, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h3C, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h3C, 0);
    // 10 CPU reads while host write 0x30=77 is pending
    add(1, 0, 8'h20, 8'h00, 1, 1, 8'h30, 8'h77, 8'h3C, 1, 0, 8'h3C, 0);
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0)
        add(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 8'hA5, 1, 0, 8'h3C, 0);
      else
        add(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 8'h3C, 1, 0, 8'h3C, 0);
    end
    add(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h3C, 0);
    add(1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 8'h00, 8'h77, 0, 0, 8'h3C, 0);
    // overrun: second request one cycle after the first is dropped
    add(0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00, 8'h00, 1, 0, 8'h3C, 0);
    add(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'hFF, 8'h00, 1, 1, 8'h77, 1);
    add(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h77, 1);
    add(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 8'hA5, 0, 0, 8'h77, 1);
    // request accepted alongside a CPU write; top address 0xFF
    add(0, 1, 8'h00, 8'h11, 1, 1, 8'hFF, 8'hC3, 8'h00, 1, 0, 8'h77, 1);
    add(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h11, 1, 0, 8'h77, 1);
    add(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h77, 1);
    add(1, 0, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00, 8'hC3, 0, 0, 8'h77, 1);
    // CPU read+write same cycle returns old data
    add(1, 1, 8'hFF, 8'h99, 0, 0, 8'h00, 8'h00, 8'hC3, 0, 0, 8'h77, 1);
    add(1, 0, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00, 8'h99, 0, 0, 8'h77, 1);
    // request in the DONE cycle is ignored
    add(0, 0, 8'h00, 8'h00, 1, 0, 8'hFF, 8'h00, 8'h00, 1, 0, 8'h77, 1);
    add(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h99, 1);
    add(0, 0, 8'h00, 8'h00, 1, 1, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h99, 1);
    add(1, 0, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00, 8'h99, 0, 0, 8'h99, 1);

    foreach (tbl[i]) begin
      cpu_read = tbl[i].rd; cpu_write = tbl[i].wr;
      cpu_address = tbl[i].ca; cpu_D = tbl[i].cd;
      host_req = tbl[i].hreq; host_we = tbl[i].hwe;
      host_addr = tbl[i].ha; host_wdata = tbl[i].hwd;
      step();
      chk($sformatf("v%0d cpu_Q", i), cpu_Q, tbl[i].eq);
      chk($sformatf("v%0d busy", i), host_busy, tbl[i].ebusy);
      chk($sformatf("v%0d ack", i), host_ack, tbl[i].eack);
      chk($sformatf("v%0d rdata", i), host_rdata, tbl[i].erd);
      chk($sformatf("v%0d overrun", i), host_overrun, tbl[i].eovr);
    end

    // reset while a host write to 0x40 is pending
    idle_inputs();
    cpu_write = 1'b1; cpu_address = 8'h40; cpu_D = 8'h12;
    step();
    idle_inputs();
    cpu_read = 1'b1; cpu_address = 8'h40;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'hEE;
    step();
    chk("r6 busy pending", host_busy, 1);
    for (int i = 0; i < 3; i++) begin
      cpu_rd(8'h40);
      chk("r6 no ack cpu busy", host_ack, 0);
    end
    idle_inputs();
    reset = 1'b1;
    step();
    chk("r6 busy in reset", host_busy, 0);
    chk("r6 ack in reset", host_ack, 0);
    chk("r6 overrun in reset", host_overrun, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r6 no ack after reset", host_ack, 0);
      chk("r6 idle after reset", host_busy, 0);
    end
    cpu_rd(8'h40);
    chk("r6 mem 0x40 intact", cpu_Q, 8'h12);

`ifdef MEM_ARB_STARVE_EN
    begin
      int hold_at = 0;
      int ack_at  = 0;
      int holds   = 0;
      idle_inputs();
      cpu_write = 1'b1; cpu_address = 8'h08; cpu_D = 8'h5C;
      step();
      idle_inputs();
      cpu_write = 1'b1; cpu_address = 8'h07; cpu_D = 8'h00;
      host_req = 1'b1; host_we = 1'b1; host_addr = 8'h05; host_wdata = 8'hB4;
      step();
      for (int i = 1; i <= 40 && ack_at == 0; i++) begin
        idle_inputs();
        cpu_write = 1'b1;
        cpu_address = cpu_hold ? 8'h08 : 8'h07;
        cpu_D = cpu_hold ? 8'hDD : 8'(i);
        step();
        if (cpu_hold) begin
          holds++;
          hold_at = i;
        end
        if (host_ack) ack_at = i;
      end
      chk("s5 hold cycle", hold_at, 17);
      chk("s5 hold pulses", holds, 1);
      chk("s5 ack cycle", ack_at, 18);
      chk("s5 conflict", cpu_conflict, 1);
      cpu_rd(8'h05);
      chk("s5 host write landed", cpu_Q, 8'hB4);
      cpu_rd(8'h08);
      chk("s5 cpu write dropped", cpu_Q, 8'h5C);
    end
`else
    chk("hold tied low", cpu_hold, 0);
    chk("conflict tied low", cpu_conflict, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Owns the single-port 256x8 data memory and shares it between the discus CPU data port and the SPI host (debug/load) port. The CPU has fixed-latency priority access. Host accesses are accepted one at a time through a req/busy/ack handshake and executed in CPU-idle cycles. The block sits between the CPU, the SPI command decoder and the memory array, which it contains.

Parameters:
AW, 8, address width; memory depth is 2**AW.
DW, 8, data width.
STARVE_LIMIT, 16, cycles a host request may wait before a forced slot (used only with the optional feature).
CW, 5, wait-counter width; must satisfy 2**CW > STARVE_LIMIT.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
cpu_read  in  1  CPU read strobe for this cycle.
cpu_write  in  1  CPU write strobe for this cycle.
cpu_address  in  AW  CPU address.
cpu_D  in  DW  CPU write data.
cpu_Q  out  DW  CPU read data, registered.
host_req  in  1  single-cycle host request pulse.
host_we  in  1  1 = write, 0 = read; sampled with host_req.
host_addr  in  AW  host address; sampled with host_req.
host_wdata  in  DW  host write data; sampled with host_req.
host_busy  out  1  a host request is latched and not yet acknowledged.
host_ack  out  1  one-cycle completion pulse.
host_rdata  out  DW  host read data; valid from host_ack and held until the next ack.
host_overrun  out  1  sticky: host_req arrived while host_busy=1.
cpu_hold  out  1  forced host slot; the CPU must not access memory in this cycle.
cpu_conflict  out  1  sticky: CPU accessed memory while cpu_hold=1.

Behaviour:
- Reset values: cpu_Q=0, host_busy=0, host_ack=0, host_rdata=0, host_overrun=0, cpu_hold=0, cpu_conflict=0, state=IDLE, wait counter=0. Memory contents are not reset.
- CPU path, every cycle, zero wait states:
  - Write: if cpu_write, mem[cpu_address] <= cpu_D.
  - Read: cpu_Q <= cpu_read ? mem[cpu_address] : 0, visible the next cycle.
  - Read and write in the same cycle: the write lands and cpu_Q returns the old data (read-before-write).
- CPU idle cycle: cpu_read=0 and cpu_write=0.
- State machine IDLE -> PEND -> DONE -> IDLE:
  - IDLE: on host_req, latch we/addr/wdata, host_busy<=1, go to PEND. Without host_req, stay in IDLE.
  - PEND: in the first CPU-idle cycle (or forced slot), perform the host access.
    - Write: mem[addr] <= wdata.
    - Read: host_rdata <= mem[addr].
    - Then go to DONE.
  - DONE: host_ack=1 for exactly this cycle, host_busy<=0, go to IDLE.
- Latency:
  - host_req at cycle N with the CPU idle gives: access at N+1, host_ack at N+2, host_busy low from N+3.
  - Minimum spacing between accepted requests is 3 cycles.
- host_req while host_busy=1, or in the DONE cycle, is ignored and sets host_overrun. host_overrun clears only on reset.
- host_req in IDLE is always accepted, whatever the CPU is doing.
- Host access and CPU access never share a cycle, so there is no same-cycle address collision.
- A host write followed by a CPU read of the same address reads the new value. A CPU write followed by a host read returns the CPU data.
- Address arithmetic: none; addresses are used as given, and the full range 0..2**AW-1 is valid.
- Reset mid-operation: any latched request is discarded with no ack. A host write still in PEND does not reach memory.

Optional Feature:
Macro: MEM_ARB_STARVE_EN.
- Defined:
  - The wait counter increments each cycle in PEND when no host access occurs, and clears on leaving PEND.
  - When the counter equals STARVE_LIMIT, cpu_hold<=1 for exactly one cycle. The host access is performed in that cpu_hold cycle regardless of the CPU strobes.
  - Any CPU read or write in the cpu_hold cycle is suppressed: no write, cpu_Q<=0. It also sets cpu_conflict.
  - Worst-case host latency is STARVE_LIMIT+3 cycles.
- Not defined: cpu_hold and cpu_conflict are tied 0, there is no counter, and a host request waits indefinitely for an idle cycle.

Test Plan:
1. Reset, then host write addr 0x10 data 0xA5 with the CPU idle -> host_ack 2 cycles after req. Then a CPU read of 0x10 gives cpu_Q=0xA5 the next cycle.
2. CPU writes 0x3C to 0x20, then the host reads 0x20 -> host_rdata=0x3C at host_ack; host_rdata holds 0x3C afterwards.
3. CPU reads continuously for 10 cycles while a host write is pending -> no ack during those cycles and cpu_Q values are unaffected. The access happens on the first idle cycle, and ack follows one cycle later.
4. Second host_req one cycle after the first -> ignored and host_overrun=1. The first request completes normally, and host_overrun stays 1 until reset.
5. With MEM_ARB_STARVE_EN and STARVE_LIMIT=16, CPU busy forever and a host write to 0x05 pending -> cpu_hold pulses once and the host write completes with ack. The CPU write in the hold cycle is dropped and cpu_conflict=1.
6. Host write to 0x40 pending (CPU busy), then reset asserted -> no host_ack, busy=0, and mem[0x40] is unchanged when read back after reset.
